// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV64I control FSM.
// Holds the state enum, supported opcodes and ALU operation codes.
package mc_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned ALU_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALU_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALU_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALU_W-1:0] ALU_FUNCT = 2'b10;

    function automatic logic opcode_legal(input logic [OPC_W-1:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Single shared memory port handshake between controller and memory.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mc_wait_timer.sv
// Counts consecutive unanswered memory-request cycles; flags the cycle that
// would reach the limit so the controller can abandon the request.
module mc_wait_timer #(
    parameter int unsigned TMR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [TMR_W-1:0] limit,
    output logic             expired
);

    logic [TMR_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + TMR_W'(1);
        end
    end

    // Fires on the wait cycle whose increment would land on the limit.
    assign expired = inc && (count_q == (limit - TMR_W'(1)));

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV64I datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes, owns the memory handshake, timeout fault and instret.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMR_W       = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [OPC_W-1:0]      opcode,
    input  logic                  zero,
    multicycle_controller_if.master mem,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic                  alu_src_b,
    output logic [ALU_W-1:0]      alu_op,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic                  busy,
    output logic                  fault,
    output logic [CNT_W-1:0]      instret
);

    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MEM_TIMEOUT);

    state_t             state_q;
    state_t             state_d;
    logic [OPC_W-1:0]   op_q;
    logic [CNT_W-1:0]   instret_q;
    logic               fault_q;
    logic               retire;
    logic               fault_set;
    logic               mem_req_c;
    logic               mem_we_c;
    logic               mem_wait;
    logic               tmr_expired;

    // Waiting is derived from state alone so the timer never loops through the decode.
    assign mem_wait = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem.mem_ready;

    mc_wait_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!mem_wait),
        .inc     (mem_wait),
        .limit   (TMR_LIMIT),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            instret_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        fault_set  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (tmr_expired) begin
                    fault_set = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (opcode_legal(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    fault_set = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_EXEC: begin
                unique case (op_q)
                    OP_R: begin
                        alu_op  = ALU_FUNCT;
                        state_d = ST_WB;
                    end
                    OP_I: begin
                        alu_op    = ALU_FUNCT;
                        alu_src_b = 1'b1;
                        state_d   = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_op    = ALU_ADD;
                        alu_src_b = 1'b1;
                        state_d   = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op   = ALU_SUB;
                        pc_write = zero;
                        pc_src   = zero;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: begin
                        fault_set = 1'b1;
                        state_d   = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (op_q == OP_STORE);
                if (mem.mem_ready) begin
                    if (op_q == OP_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmr_expired) begin
                    fault_set = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LOAD);
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    assign mem.mem_req = mem_req_c;
    assign mem.mem_we  = mem_we_c;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign fault       = fault_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; a second instance with a 2-bit
// instret runs in lockstep to exercise counter wrap-around.
module tb_multicycle_controller;
    import mc_pkg::*;

    logic       clk;
    logic       reset;
    logic       run;
    logic [6:0] opcode;
    logic       zero;
    logic       ready;

    logic        ir_write, pc_write, pc_src, alu_src_b, reg_write, mem_to_reg, busy, fault;
    logic [1:0]  alu_op;
    logic [31:0] instret;

    logic        s_ir_write, s_pc_write, s_pc_src, s_alu_src_b, s_reg_write, s_mem_to_reg;
    logic        s_busy, s_fault;
    logic [1:0]  s_alu_op;
    logic [1:0]  s_instret;

    int n_checks;
    int n_fail;

    multicycle_controller_if mem_a ();
    multicycle_controller_if mem_b ();
    assign mem_a.mem_ready = ready;
    assign mem_b.mem_ready = ready;

    multicycle_controller #(.MEM_TIMEOUT(15), .TMR_W(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero), .mem(mem_a),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .busy(busy),
        .fault(fault), .instret(instret)
    );

    multicycle_controller #(.MEM_TIMEOUT(15), .TMR_W(4), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero), .mem(mem_b),
        .ir_write(s_ir_write), .pc_write(s_pc_write), .pc_src(s_pc_src),
        .alu_src_b(s_alu_src_b), .alu_op(s_alu_op), .reg_write(s_reg_write),
        .mem_to_reg(s_mem_to_reg), .busy(s_busy), .fault(s_fault), .instret(s_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chks(input string tag, input state_t obs, input state_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; run = 1'b0; opcode = 7'd0; zero = 1'b0; ready = 1'b1;

        // Reset state
        tick(); tick();
        chks("rst_state", dut.state_q, ST_IDLE);
        chk1("rst_mem_req", mem_a.mem_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ir_write", ir_write, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk32("rst_instret", instret, 32'd0);

        // R-type, ready tied high: FETCH, DECODE, EXEC, WB
        reset = 1'b0; opcode = OP_R; run = 1'b1;
        tick();
        chks("r_fetch_state", dut.state_q, ST_FETCH);
        chk1("r_fetch_req", mem_a.mem_req, 1'b1);
        chk1("r_fetch_we", mem_a.mem_we, 1'b0);
        chk1("r_fetch_irw", ir_write, 1'b1);
        chk1("r_fetch_pcw", pc_write, 1'b1);
        chk1("r_fetch_pcsrc", pc_src, 1'b0);
        chk1("r_fetch_busy", busy, 1'b1);
        run = 1'b0;
        tick();
        chks("r_decode_state", dut.state_q, ST_DECODE);
        chk1("r_decode_req", mem_a.mem_req, 1'b0);
        chk1("r_decode_regw", reg_write, 1'b0);
        tick();
        chks("r_exec_state", dut.state_q, ST_EXEC);
        chk2("r_exec_aluop", alu_op, ALU_FUNCT);
        chk1("r_exec_srcb", alu_src_b, 1'b0);
        chk1("r_exec_regw", reg_write, 1'b0);
        tick();
        chks("r_wb_state", dut.state_q, ST_WB);
        chk1("r_wb_regw", reg_write, 1'b1);
        chk1("r_wb_m2r", mem_to_reg, 1'b0);
        chk32("r_wb_instret", instret, 32'd0);
        opcode = OP_LOAD;
        tick();
        chks("r_next_fetch", dut.state_q, ST_FETCH);
        chk32("r_retired", instret, 32'd1);
        chk1("r_next_regw", reg_write, 1'b0);

        // LOAD with three wait cycles in MEM
        tick(); tick();
        chks("ld_exec_state", dut.state_q, ST_EXEC);
        chk2("ld_exec_aluop", alu_op, ALU_ADD);
        chk1("ld_exec_srcb", alu_src_b, 1'b1);
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) begin
                ready = 1'b1;
                #1;
            end
            chks("ld_mem_state", dut.state_q, ST_MEM);
            chk1("ld_mem_req", mem_a.mem_req, 1'b1);
            chk1("ld_mem_we", mem_a.mem_we, 1'b0);
        end
        tick();
        chks("ld_wb_state", dut.state_q, ST_WB);
        chk1("ld_wb_regw", reg_write, 1'b1);
        chk1("ld_wb_m2r", mem_to_reg, 1'b1);
        chk32("ld_wb_instret", instret, 32'd1);
        opcode = OP_BRANCH; zero = 1'b1;
        tick();
        chk32("ld_retired", instret, 32'd2);

        // BRANCH taken then not taken, three cycles each
        tick(); tick();
        chks("bt_exec_state", dut.state_q, ST_EXEC);
        chk2("bt_aluop", alu_op, ALU_SUB);
        chk1("bt_srcb", alu_src_b, 1'b0);
        chk1("bt_pcw", pc_write, 1'b1);
        chk1("bt_pcsrc", pc_src, 1'b1);
        zero = 1'b0;
        tick();
        chks("bt_next_fetch", dut.state_q, ST_FETCH);
        chk32("bt_retired", instret, 32'd3);
        chk2("small_instret_3", s_instret, 2'd3);
        tick(); tick();
        chks("bn_exec_state", dut.state_q, ST_EXEC);
        chk1("bn_pcw", pc_write, 1'b0);
        chk1("bn_pcsrc", pc_src, 1'b0);
        opcode = OP_STORE;
        tick();
        chk32("bn_retired", instret, 32'd4);
        chk2("small_instret_wrap", s_instret, 2'd0);

        // STORE, ready high: retires from MEM after 4 cycles
        tick(); tick();
        chk1("st_exec_srcb", alu_src_b, 1'b1);
        tick();
        chks("st_mem_state", dut.state_q, ST_MEM);
        chk1("st_mem_req", mem_a.mem_req, 1'b1);
        chk1("st_mem_we", mem_a.mem_we, 1'b1);
        tick();
        chks("st_next_fetch", dut.state_q, ST_FETCH);
        chk32("st_retired", instret, 32'd5);

        // Second STORE aborted by reset while waiting in MEM
        tick(); tick(); ready = 1'b0;
        tick();
        chk1("st2_mem_we", mem_a.mem_we, 1'b1);
        tick();
        chk1("st2_we_stable", mem_a.mem_we, 1'b1);
        reset = 1'b1;
        tick();
        chks("abort_state", dut.state_q, ST_IDLE);
        chk1("abort_we", mem_a.mem_we, 1'b0);
        chk1("abort_regw", reg_write, 1'b0);
        chk1("abort_fault", fault, 1'b0);
        chk32("abort_instret", instret, 32'd0);

        // Illegal opcode halts after DECODE
        reset = 1'b0; ready = 1'b1; opcode = 7'b1111111; run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        chk1("ill_decode_fault", fault, 1'b0);
        tick();
        chks("ill_halt_state", dut.state_q, ST_HALT);
        chk1("ill_fault", fault, 1'b1);
        chk1("ill_busy", busy, 1'b0);
        chk1("ill_req", mem_a.mem_req, 1'b0);
        chk32("ill_instret", instret, 32'd0);
        run = 1'b1;
        tick();
        chks("halt_sticky", dut.state_q, ST_HALT);

        // FETCH timeout after 15 unanswered cycles
        reset = 1'b1;
        tick();
        reset = 1'b0; ready = 1'b0; opcode = OP_R; run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chks("to_fetch_state", dut.state_q, ST_FETCH);
            chk1("to_fetch_irw", ir_write, 1'b0);
            tick();
        end
        chks("to_halt_state", dut.state_q, ST_HALT);
        chk1("to_fault", fault, 1'b1);
        chk1("to_req", mem_a.mem_req, 1'b0);

        // Ready on the 15th wait cycle wins over the timeout
        reset = 1'b1;
        tick();
        chk1("rst_clears_fault", fault, 1'b0);
        reset = 1'b0; run = 1'b1; opcode = OP_I;
        tick();
        run = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        ready = 1'b1;
        #1;
        chks("rw_fetch_state", dut.state_q, ST_FETCH);
        chk1("rw_irw", ir_write, 1'b1);
        tick();
        chks("rw_decode_state", dut.state_q, ST_DECODE);
        chk1("rw_fault", fault, 1'b0);
        tick();
        chk2("i_exec_aluop", alu_op, ALU_FUNCT);
        chk1("i_exec_srcb", alu_src_b, 1'b1);
        tick();
        chk1("i_wb_regw", reg_write, 1'b1);
        chk1("i_wb_m2r", mem_to_reg, 1'b0);
        tick();
        chk32("i_retired", instret, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
